// File: rtl/irq_gateway_pkg.sv
// Shared constants and types for the external-interrupt gateway.
// The edge-mode feature is selected with the IRQ_GW_EDGE_EN macro.
package irq_gateway_pkg;

    localparam int IRQ_EXT_BASE = 2;
    localparam int IRQ_VEC_W    = 32;

    typedef enum logic {
        CFG_SEL_MASK = 1'b0,
        CFG_SEL_EDGE = 1'b1
    } cfg_sel_e;

    typedef logic [4:0] irq_id_t;

endpackage

// File: rtl/irq_gateway_if.sv
// Signal bundle between the gateway, its configuration master, the
// peripheral request lines and the IRQ unit.
interface irq_gateway_if
    import irq_gateway_pkg::*;
#(
    parameter int NSRC = 30
);
    // No valid/ready pairs: cfg_we is a single-cycle strobe that is always
    // accepted at the edge where it is high; inirr is a level vector and ack
    // is a per-bit pulse that the IRQ unit raises for at least one cycle.
    logic [NSRC-1:0]      irq_src;
    logic                 cfg_we;
    logic                 cfg_sel;
    logic [IRQ_VEC_W-1:0] cfg_wdata;
    logic [IRQ_VEC_W-1:0] cfg_rdata;
    logic [IRQ_VEC_W-1:0] ack;
    logic [IRQ_VEC_W-1:0] inirr;
    logic                 top_valid;
    irq_id_t              top_id;

    modport master (
        output irq_src, cfg_we, cfg_sel, cfg_wdata, ack,
        input  cfg_rdata, inirr, top_valid, top_id
    );

    modport slave (
        input  irq_src, cfg_we, cfg_sel, cfg_wdata, ack,
        output cfg_rdata, inirr, top_valid, top_id
    );

endinterface

// File: rtl/irq_sync_cell.sv
// One source: input synchroniser, previous-level flop and pending bit.
// Edge detection and ack-clear exist only when IRQ_GW_EDGE_EN is defined.
module irq_sync_cell #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic en,
`ifdef IRQ_GW_EDGE_EN
    input  logic edge_mode,
    input  logic ack,
`endif
    input  logic cfg_clr,
    output logic pend
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pend_q, pend_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

`ifdef IRQ_GW_EDGE_EN
    logic prev_q, prev_d;
    logic set_edge;

    always_comb begin
        prev_d   = s;
        set_edge = s & ~prev_q & en;
        sync_d   = {sync_q[SYNC_STAGES-2:0], src};
        if (edge_mode) begin
            // A new edge beats a simultaneous ack so no request is dropped.
            pend_d = set_edge | (pend_q & ~ack);
        end else begin
            pend_d = s & en;
        end
        if (cfg_clr) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], src};
        pend_d = s & en;
        if (cfg_clr) begin
            pend_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/irq_gateway.sv
// External-interrupt gateway: per-source enable/mode, pending vector to the
// IRQ unit and lowest-index priority encoder. Edge mode needs IRQ_GW_EDGE_EN.
module irq_gateway
    import irq_gateway_pkg::*;
#(
    parameter int NSRC        = 30,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    irq_gateway_if.slave  bus
);

    logic [NSRC-1:0]      en_q, en_d;
    logic [NSRC-1:0]      cfg_clr;
    logic [NSRC-1:0]      pend_vec;
    logic [IRQ_VEC_W-1:0] inirr;
    logic [IRQ_VEC_W-1:0] rdata;
    logic                 top_valid;
    irq_id_t              top_id;
    logic                 mask_wr;
    logic                 unused_bits;

    assign mask_wr     = bus.cfg_we && (bus.cfg_sel == CFG_SEL_MASK);
    assign unused_bits = ^{bus.cfg_wdata, bus.ack};

`ifdef IRQ_GW_EDGE_EN
    logic [NSRC-1:0] edge_q, edge_d;
    logic            edge_wr;

    assign edge_wr = bus.cfg_we && (bus.cfg_sel == CFG_SEL_EDGE);

    // A source whose enable drops or whose mode flips loses its pending bit.
    always_comb begin
        en_d    = en_q;
        edge_d  = edge_q;
        cfg_clr = '0;
        if (mask_wr) begin
            en_d    = bus.cfg_wdata[IRQ_EXT_BASE +: NSRC];
            cfg_clr = en_q & ~en_d;
        end
        if (edge_wr) begin
            edge_d  = bus.cfg_wdata[IRQ_EXT_BASE +: NSRC];
            cfg_clr = edge_q ^ edge_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q <= '0;
        end else begin
            edge_q <= edge_d;
        end
    end
`else
    always_comb begin
        en_d    = en_q;
        cfg_clr = '0;
        if (mask_wr) begin
            en_d    = bus.cfg_wdata[IRQ_EXT_BASE +: NSRC];
            cfg_clr = en_q & ~en_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= '0;
        end else begin
            en_q <= en_d;
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        irq_sync_cell #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .src       (bus.irq_src[i]),
            .en        (en_q[i]),
`ifdef IRQ_GW_EDGE_EN
            .edge_mode (edge_q[i]),
            .ack       (bus.ack[i+IRQ_EXT_BASE]),
`endif
            .cfg_clr   (cfg_clr[i]),
            .pend      (pend_vec[i])
        );
    end

    always_comb begin
        inirr = '0;
        inirr[IRQ_EXT_BASE +: NSRC] = pend_vec;
    end

    always_comb begin
        rdata = '0;
        if (bus.cfg_sel == CFG_SEL_MASK) begin
            rdata[IRQ_EXT_BASE +: NSRC] = en_q;
        end else begin
`ifdef IRQ_GW_EDGE_EN
            rdata[IRQ_EXT_BASE +: NSRC] = edge_q;
`endif
        end
    end

    // Scan downwards so the lowest set index is the one left in top_id.
    always_comb begin
        top_valid = |inirr;
        top_id    = '0;
        for (int i = IRQ_VEC_W - 1; i >= IRQ_EXT_BASE; i--) begin
            if (inirr[i]) begin
                top_id = irq_id_t'(i);
            end
        end
    end

    assign bus.inirr     = inirr;
    assign bus.cfg_rdata = rdata;
    assign bus.top_valid = top_valid;
    assign bus.top_id    = top_id;

endmodule

// File: tb/tb_irq_gateway.sv
// Directed bench for irq_gateway: the driver queues hand-computed expected
// outputs and a negedge monitor compares them against the DUT.
module tb_irq_gateway;
    import irq_gateway_pkg::*;

    localparam int EW = 32 + 1 + 5 + 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    irq_gateway_if #(.NSRC(30)) bus ();

    irq_gateway #(
        .NSRC        (30),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] e_irr,
                       input logic [4:0] e_id, input logic [31:0] e_rd);
        exp_q.push_back({e_irr, (e_id != 5'd0), e_id, e_rd});
        name_q.push_back(nm);
    endtask

    task automatic cfg_write(input logic sel, input logic [31:0] data);
        bus.cfg_sel   = sel;
        bus.cfg_wdata = data;
        bus.cfg_we    = 1'b1;
        tick();
        bus.cfg_we    = 1'b0;
        bus.cfg_sel   = 1'b0;
        bus.cfg_wdata = '0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            string         nm;
            logic [31:0]   e_irr, e_rd;
            logic          e_tv;
            logic [4:0]    e_id;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            {e_irr, e_tv, e_id, e_rd} = e;
            n_checks++;
            if (bus.inirr !== e_irr || bus.top_valid !== e_tv ||
                bus.top_id !== e_id || bus.cfg_rdata !== e_rd) begin
                n_fail++;
                $display("FAIL %s: got inirr=%h valid=%b id=%0d rdata=%h, want inirr=%h valid=%b id=%0d rdata=%h",
                         nm, bus.inirr, bus.top_valid, bus.top_id, bus.cfg_rdata,
                         e_irr, e_tv, e_id, e_rd);
            end
        end
    end

    initial begin
        bus.irq_src   = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_sel   = 1'b0;
        bus.cfg_wdata = '0;
        bus.ack       = '0;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;

        // Reset state, both readback selects
        chk("reset_sel0", 32'h0, 5'd0, 32'h0);
        tick();
        bus.cfg_sel = 1'b1;
        chk("reset_sel1", 32'h0, 5'd0, 32'h0);
        tick();
        bus.cfg_sel = 1'b0;

        // Level mode on source 2; source 3 is masked off
        cfg_write(1'b0, 32'h0000_0010);
        chk("mask_readback", 32'h0, 5'd0, 32'h0000_0010);
        bus.irq_src[2] = 1'b1;
        bus.irq_src[3] = 1'b1;
        tick();
        chk("lvl_rise_c1", 32'h0, 5'd0, 32'h0000_0010);
        tick();
        chk("lvl_rise_c2", 32'h0, 5'd0, 32'h0000_0010);
        tick();
        chk("lvl_rise_c3", 32'h0000_0010, 5'd4, 32'h0000_0010);
        for (int c = 4; c <= 10; c++) begin
            bus.ack = (c % 2 == 0) ? 32'h0000_0010 : 32'h0;
            tick();
            chk("lvl_hold_ack", 32'h0000_0010, 5'd4, 32'h0000_0010);
        end
        bus.ack        = '0;
        bus.irq_src[2] = 1'b0;
        bus.irq_src[3] = 1'b0;
        ticks(2);
        chk("lvl_fall_c2", 32'h0000_0010, 5'd4, 32'h0000_0010);
        tick();
        chk("lvl_fall_c3", 32'h0, 5'd0, 32'h0000_0010);

        // Two level sources, lowest index wins; then mask one off
        cfg_write(1'b0, 32'h8000_0004);
        bus.irq_src[0]  = 1'b1;
        bus.irq_src[29] = 1'b1;
        ticks(2);
        chk("two_src_c2", 32'h0, 5'd0, 32'h8000_0004);
        tick();
        chk("two_src_c3", 32'h8000_0004, 5'd2, 32'h8000_0004);
        cfg_write(1'b0, 32'h8000_0000);
        chk("mask_drop_src0", 32'h8000_0000, 5'd31, 32'h8000_0000);
        bus.irq_src[0]  = 1'b0;
        bus.irq_src[29] = 1'b0;
        ticks(3);
        chk("two_src_clear", 32'h0, 5'd0, 32'h8000_0000);

        // Level request dropped by reset, no return until re-enabled
        cfg_write(1'b0, 32'h0000_0010);
        bus.irq_src[2] = 1'b1;
        ticks(3);
        chk("lvl_pre_rst", 32'h0000_0010, 5'd4, 32'h0000_0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lvl_rst_clear", 32'h0, 5'd0, 32'h0);
        ticks(3);
        chk("lvl_rst_no_en", 32'h0, 5'd0, 32'h0);
        cfg_write(1'b0, 32'h0000_0010);
        tick();
        chk("lvl_reenable", 32'h0000_0010, 5'd4, 32'h0000_0010);
        bus.irq_src[2] = 1'b0;
        ticks(3);
        chk("lvl_rst_done", 32'h0, 5'd0, 32'h0000_0010);
        cfg_write(1'b0, 32'h0);

`ifdef IRQ_GW_EDGE_EN
        // Edge mode on sources 6 and 7
        cfg_write(1'b0, 32'h0000_0300);
        cfg_write(1'b1, 32'h0000_0300);
        bus.cfg_sel = 1'b1;
        chk("edge_readback", 32'h0, 5'd0, 32'h0000_0300);
        tick();
        bus.cfg_sel = 1'b0;
        bus.irq_src[6] = 1'b1;
        ticks(2);
        bus.irq_src[6] = 1'b0;
        chk("edge_c2", 32'h0, 5'd0, 32'h0000_0300);
        tick();
        chk("edge_set", 32'h0000_0100, 5'd8, 32'h0000_0300);
        ticks(4);
        chk("edge_hold", 32'h0000_0100, 5'd8, 32'h0000_0300);
        bus.ack = 32'h0000_0100;
        tick();
        bus.ack = '0;
        chk("edge_ack_clr", 32'h0, 5'd0, 32'h0000_0300);

        // New edge in the same cycle as ack: set wins
        bus.irq_src[6] = 1'b1;
        ticks(3);
        chk("edge_reset_pend", 32'h0000_0100, 5'd8, 32'h0000_0300);
        bus.irq_src[6] = 1'b0;
        ticks(3);
        bus.irq_src[6] = 1'b1;
        ticks(2);
        bus.ack = 32'h0000_0100;
        tick();
        bus.ack = '0;
        chk("set_beats_ack", 32'h0000_0100, 5'd8, 32'h0000_0300);
        tick();
        chk("set_beats_ack_hold", 32'h0000_0100, 5'd8, 32'h0000_0300);
        bus.ack = 32'h0000_0100;
        tick();
        bus.ack = '0;
        ticks(2);
        chk("no_edge_while_high", 32'h0, 5'd0, 32'h0000_0300);

        // Reset with pending edge and line still high
        bus.irq_src[6] = 1'b0;
        ticks(3);
        bus.irq_src[6] = 1'b1;
        ticks(3);
        chk("edge_pre_rst", 32'h0000_0100, 5'd8, 32'h0000_0300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("edge_rst_clear", 32'h0, 5'd0, 32'h0);
        ticks(4);
        cfg_write(1'b0, 32'h0000_0300);
        cfg_write(1'b1, 32'h0000_0300);
        ticks(3);
        chk("edge_no_retrigger", 32'h0, 5'd0, 32'h0000_0300);
        bus.irq_src[6] = 1'b0;
        ticks(3);
        bus.irq_src[6] = 1'b1;
        ticks(3);
        chk("edge_retrigger", 32'h0000_0100, 5'd8, 32'h0000_0300);

        // Flipping the mode clears the pending bit
        cfg_write(1'b1, 32'h0000_0200);
        chk("mode_flip_clr", 32'h0, 5'd0, 32'h0000_0300);
        bus.irq_src[6] = 1'b0;
`else
        // Without edge support the mode register is absent and ack unused
        cfg_write(1'b1, 32'hFFFF_FFFC);
        bus.cfg_sel = 1'b1;
        chk("edge_reg_absent", 32'h0, 5'd0, 32'h0);
        tick();
        bus.cfg_sel = 1'b0;
        cfg_write(1'b0, 32'h0000_0100);
        bus.irq_src[6] = 1'b1;
        ticks(2);
        bus.irq_src[6] = 1'b0;
        tick();
        chk("pulse_level_c3", 32'h0000_0100, 5'd8, 32'h0000_0100);
        tick();
        chk("pulse_level_c4", 32'h0000_0100, 5'd8, 32'h0000_0100);
        tick();
        chk("pulse_level_gone", 32'h0, 5'd0, 32'h0000_0100);
        bus.irq_src[6] = 1'b1;
        ticks(3);
        bus.ack = 32'hFFFF_FFFF;
        tick();
        bus.ack = '0;
        chk("ack_ignored", 32'h0000_0100, 5'd8, 32'h0000_0100);
        bus.irq_src[6] = 1'b0;
`endif

        tick();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_gateway.md
# irq_gateway

External-interrupt front end for the IRQ unit: synchronises up to 30 asynchronous peripheral request lines, applies per-line enable and level/edge mode, and holds edge requests pending until the IRQ unit acknowledges them. The block drives the IRQ unit's `inirr` bus bits [31:2] and consumes its `outirr` acknowledge bus. It also exposes a highest-priority pending index for debug and for PC-vector selection logic.

## Interface
Parameters:
- `NSRC`, 30: number of external sources, mapped to `inirr[NSRC+1:2]`; legal range 1..30.
- `SYNC_STAGES`, 2: flip-flop depth of each input synchroniser; minimum 2.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, synchronous, active-high.
- `irq_src`  in  NSRC  raw asynchronous requests; bit i maps to `inirr[i+2]`.
- `cfg_we`  in  1  configuration write strobe, one cycle.
- `cfg_sel`  in  1  0 = enable-mask register, 1 = edge-mode register.
- `cfg_wdata`  in  32  write data; bit k of `cfg_wdata` addresses source k-2; bits [1:0] ignored.
- `cfg_rdata`  out  32  combinational readback of the register selected by `cfg_sel`; bits [1:0] read 0.
- `ack`  in  32  acknowledge bus, connected to IRQ `outirr`; bits [1:0] ignored.
- `inirr`  out  32  masked pending vector to the IRQ unit; bits [1:0] are always 0.
- `top_valid`  out  1  high when any `inirr` bit is set.
- `top_id`  out  5  index (2..31) of the lowest-numbered set `inirr` bit; 0 when `top_valid` is 0.

## Operation
- Per-source state is `sync` chain, `prev` (last synchronised value), `pend`, `en` (mask) and `edge` (mode). All of these reset to 0. After reset, `inirr`, `top_valid`, `top_id` and `cfg_rdata` are all 0.
- Synchronised level: `s = sync[SYNC_STAGES-1]`. `prev <= s` every cycle.
- **Level mode** (`edge=0`): `pend <= s & en`. `ack` has no effect; the source must deassert its line.
- **Edge mode** (`edge=1`): the set term is `s & ~prev & en`.
  - `pend` becomes 1 on the set term.
  - `pend` is cleared by `ack[i+2]`.
  - Set and ack in the same cycle: set wins, and `pend` stays 1.
- `inirr[i+2] = pend[i]`, taken from registers with no combinational path from `irq_src`.
- Config write:
  - A `cfg_we` write replaces the whole selected register.
  - Clearing an `en` bit clears that source's `pend` in the same edge.
  - Changing a source's mode clears its `pend`.
  - A config write in the same cycle as a set: the config clear wins.
- Priority: `top_id` / `top_valid` are a combinational lowest-index encoder over `inirr`.
- Unused bits above `NSRC+1` read 0 everywhere.

## Timing
- `irq_src` rise to `inirr` bit: SYNC_STAGES+1 cycles for both modes (3 at default).
- Level fall to `inirr` clear: SYNC_STAGES+1 cycles.
- `ack` asserted at edge n clears the edge-mode `pend` visible after edge n. A one-cycle ack pulse is sufficient.
- Edge pulses on `irq_src` shorter than one `clk` period may be lost. Edges are detected once per synchronised rising transition.
- Config write at edge n takes effect on `pend` at edge n. `cfg_rdata` reflects the new value after edge n.
- `rst` asserted mid-operation clears all state at the next edge, including in-flight synchroniser bits. No request survives reset.

## Configuration
- `IRQ_GW_EDGE_EN` defined:
  - The edge-mode register, edge detector and ack-clear logic are built.
  - Behaviour is as described above.
- Not defined:
  - All sources are level-sensitive.
  - The `edge` register is absent, and `cfg_rdata` reads 0 when `cfg_sel=1`.
  - Writes with `cfg_sel=1` are ignored.
  - `ack` is unused.
  - `prev` flops are not instantiated.

## Structure
- Shared package holds:
  - the `IRQ_EXT_BASE=2` bit offset,
  - the 32-bit IRQ vector width,
  - the `CFG_SEL_MASK=0` / `CFG_SEL_EDGE=1` constants,
  - the 5-bit irq-id type.
- One natural sub-module is `irq_sync_cell`: one source's synchroniser, prev and pend logic, with the mode, enable and ack for that source. It is generated NSRC times.
- The priority encoder stays in the top level.

## Test plan
- Reset, all inputs 0 -> `inirr=0`, `top_valid=0`, `top_id=0`, `cfg_rdata=0` for both selects.
- Level mode, mask = 0x0000_0010, `irq_src[2]` high for 10 cycles -> `inirr=0x0000_0010` from cycle 3 after the rise, `top_id=4`. It clears 3 cycles after the fall, and `ack` pulses in between have no effect.
- Edge mode (`IRQ_GW_EDGE_EN` defined), mask and edge = 0x0000_0300, `irq_src[6]` pulses for 2 cycles -> `inirr=0x0000_0100` holds until `ack=0x0000_0100`, then clears the next cycle.
- Edge mode: `ack[8]` asserted in the same cycle as a new edge on source 6 -> `inirr[8]` stays 1.
- Level mode, sources 0 and 29 both high -> `inirr=0x8000_0004`, `top_id=2`. Then write mask = 0x8000_0000 -> `inirr=0x8000_0000` on the next cycle, `top_id=31`.
- Edge mode, `pend` set, `rst` asserted for one cycle while `irq_src` is still high -> `inirr=0` after reset. There is no re-trigger until the line falls and rises again.
